// File: rtl/bram_dual_be_wm.sv
// rtl/bram_dual_be_wm.sv - true dual-port byte-enable RAM with per-port write modes, collision handling and clear sweep
module bram_dual_be_wm #(
  parameter int                            NB_COL         = 4,
  parameter int                            COL_WIDTH      = 8,
  parameter int                            RAM_DEPTH      = 512,
  parameter string                         WRITE_MODE_A   = "READ_FIRST",
  parameter string                         WRITE_MODE_B   = "READ_FIRST",
  parameter int                            OUT_REG        = 1,
  parameter int                            CLEAR_ON_RESET = 1,
  parameter logic [NB_COL*COL_WIDTH-1:0]   CLEAR_VALUE    = '0,
  localparam int                           ADDR_W         = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1,
  localparam int                           DATA_W         = NB_COL * COL_WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [NB_COL-1:0] wea,
  input  logic [ADDR_W-1:0] addra,
  input  logic [DATA_W-1:0] dina,
  output logic [DATA_W-1:0] douta,
  output logic              valida,
  input  logic              enb,
  input  logic [NB_COL-1:0] web,
  input  logic [ADDR_W-1:0] addrb,
  input  logic [DATA_W-1:0] dinb,
  output logic [DATA_W-1:0] doutb,
  output logic              validb,
  output logic              collision,
  output logic              init_busy
);

  localparam bit WF_A = (WRITE_MODE_A == "WRITE_FIRST");
  localparam bit NC_A = (WRITE_MODE_A == "NO_CHANGE");
  localparam bit WF_B = (WRITE_MODE_B == "WRITE_FIRST");
  localparam bit NC_B = (WRITE_MODE_B == "NO_CHANGE");
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_DEPTH - 1);

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] sweep_cnt;
  logic              sweep_last;
  logic              run;

  logic [DATA_W-1:0] mem [RAM_DEPTH];

  logic              acc_a, acc_b;
  logic              rd_a, rd_b;
  logic [DATA_W-1:0] old_a, old_b;
  logic [DATA_W-1:0] rdat_a, rdat_b;
  logic              s1_vld_a, s1_vld_b;
  logic [DATA_W-1:0] s1_dat_a, s1_dat_b;

  function automatic logic [DATA_W-1:0] merge_bytes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [NB_COL-1:0] be);
    logic [DATA_W-1:0] r;
    r = old_w;
    for (int i = 0; i < NB_COL; i++) begin
      if (be[i]) r[i*COL_WIDTH +: COL_WIDTH] = new_w[i*COL_WIDTH +: COL_WIDTH];
    end
    return r;
  endfunction

  assign run        = (state_q == ST_RUN);
  assign init_busy  = (state_q == ST_INIT);
  assign sweep_last = (sweep_cnt == LAST_ADDR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_INIT && sweep_last) state_d = ST_RUN;
  end

  // Explicit compare against the last address keeps non-power-of-two depths exact.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sweep_cnt <= '0;
    end else if (state_q == ST_INIT) begin
      sweep_cnt <= sweep_last ? '0 : sweep_cnt + ADDR_W'(1);
    end
  end

  assign acc_a = ena & run;
  assign acc_b = enb & run;
  assign old_a = mem[addra];
  assign old_b = mem[addrb];

  // A NO_CHANGE port that writes produces no read; a WRITE_FIRST port sees only its own bytes.
  assign rd_a   = acc_a & ~(NC_A & (|wea));
  assign rd_b   = acc_b & ~(NC_B & (|web));
  assign rdat_a = WF_A ? merge_bytes(old_a, dina, wea) : old_a;
  assign rdat_b = WF_B ? merge_bytes(old_b, dinb, web) : old_b;

  // Port A is written after port B so it owns any byte both ports write.
  always_ff @(posedge clk) begin
    if (init_busy) begin
      mem[sweep_cnt] <= CLEAR_VALUE;
    end else begin
      for (int i = 0; i < NB_COL; i++) begin
        if (acc_b && web[i]) mem[addrb][i*COL_WIDTH +: COL_WIDTH] <= dinb[i*COL_WIDTH +: COL_WIDTH];
        if (acc_a && wea[i]) mem[addra][i*COL_WIDTH +: COL_WIDTH] <= dina[i*COL_WIDTH +: COL_WIDTH];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_a  <= 1'b0;
      s1_vld_b  <= 1'b0;
      s1_dat_a  <= '0;
      s1_dat_b  <= '0;
      collision <= 1'b0;
    end else begin
      s1_vld_a  <= rd_a;
      s1_vld_b  <= rd_b;
      if (rd_a) s1_dat_a <= rdat_a;
      if (rd_b) s1_dat_b <= rdat_b;
      collision <= acc_a & acc_b & (addra == addrb) & ((|wea) | (|web));
    end
  end

  generate
    if (OUT_REG != 0) begin : g_oreg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          douta  <= '0;
          doutb  <= '0;
          valida <= 1'b0;
          validb <= 1'b0;
        end else begin
          valida <= s1_vld_a;
          validb <= s1_vld_b;
          if (s1_vld_a) douta <= s1_dat_a;
          if (s1_vld_b) doutb <= s1_dat_b;
        end
      end
    end else begin : g_noreg
      assign douta  = s1_dat_a;
      assign doutb  = s1_dat_b;
      assign valida = s1_vld_a;
      assign validb = s1_vld_b;
    end
  endgenerate

endmodule

// File: tb/tb_bram_dual_be_wm.sv
// tb/tb_bram_dual_be_wm.sv - self-checking bench for bram_dual_be_wm against an array/schedule reference model
module tb_bram_dual_be_wm;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        ena, enb;
  logic [3:0]  wea, web, addra, addrb;
  logic [31:0] dina, dinb;
  logic        ena2, enb2;

  logic [31:0] douta0, doutb0, douta1, doutb1;
  logic        valida0, validb0, valida1, validb1;
  logic        col0, col1, busy0, busy1;

  // The second instance is 12 deep, so accesses beyond it are masked off.
  assign ena2 = ena && (addra < 4'd12);
  assign enb2 = enb && (addrb < 4'd12);

  bram_dual_be_wm #(
    .NB_COL(4), .COL_WIDTH(8), .RAM_DEPTH(16),
    .WRITE_MODE_A("WRITE_FIRST"), .WRITE_MODE_B("READ_FIRST"),
    .OUT_REG(1), .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'hA5A5A5A5)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .ena(ena), .wea(wea), .addra(addra), .dina(dina), .douta(douta0), .valida(valida0),
    .enb(enb), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb0), .validb(validb0),
    .collision(col0), .init_busy(busy0)
  );

  bram_dual_be_wm #(
    .NB_COL(4), .COL_WIDTH(8), .RAM_DEPTH(12),
    .WRITE_MODE_A("NO_CHANGE"), .WRITE_MODE_B("WRITE_FIRST"),
    .OUT_REG(0), .CLEAR_ON_RESET(1), .CLEAR_VALUE(32'h5A5A0F0F)
  ) dut2 (
    .clk(clk), .rst_n(rst_n),
    .ena(ena2), .wea(wea), .addra(addra), .dina(dina), .douta(douta1), .valida(valida1),
    .enb(enb2), .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb1), .validb(validb1),
    .collision(col1), .init_busy(busy1)
  );

  always #5 clk = ~clk;

  // Reference model: modes 0 = READ_FIRST, 1 = WRITE_FIRST, 2 = NO_CHANGE.
  int          depth [2] = '{16, 12};
  int          lat_off [2] = '{1, 0};
  int          mode [2][2] = '{'{1, 0}, '{2, 1}};
  logic [31:0] clr [2] = '{32'hA5A5A5A5, 32'h5A5A0F0F};
  logic [31:0] mm [2][16];
  bit          run [2];
  int          idx [2];
  bit          sv [2][2][4];
  logic [31:0] sd [2][2][4];
  logic [31:0] ed [2][2];
  bit          ev [2][2];
  bit          ecol [2];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  int          fall0, fall1;

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old_w & ~mask) | (new_w & mask);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      run[m] = 1'b0;
      idx[m] = 0;
      ecol[m] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        ed[m][p] = '0;
        ev[m][p] = 1'b0;
        for (int s = 0; s < 4; s++) sv[m][p][s] = 1'b0;
      end
    end
  endtask

  task automatic sched(input int m, input int p, input logic [31:0] d);
    int s;
    s = (cyc + lat_off[m]) % 4;
    sv[m][p][s] = 1'b1;
    sd[m][p][s] = d;
  endtask

  task automatic model_edge();
    cyc++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int m = 0; m < 2; m++) begin
      bit ea, eb;
      logic [31:0] oa, ob;
      int s;
      ea = (m == 0) ? ena : ena2;
      eb = (m == 0) ? enb : enb2;
      ecol[m] = 1'b0;
      if (run[m]) begin
        oa = mm[m][addra];
        ob = mm[m][addrb];
        if (ea && !(mode[m][0] == 2 && wea != 0)) sched(m, 0, (mode[m][0] == 1) ? merge(oa, dina, wea) : oa);
        if (eb && !(mode[m][1] == 2 && web != 0)) sched(m, 1, (mode[m][1] == 1) ? merge(ob, dinb, web) : ob);
        if (eb) mm[m][addrb] = merge(mm[m][addrb], dinb, web);
        if (ea) mm[m][addra] = merge(mm[m][addra], dina, wea);
        ecol[m] = ea && eb && (addra == addrb) && (wea != 0 || web != 0);
      end else begin
        mm[m][idx[m]] = clr[m];
        idx[m]++;
        if (idx[m] == depth[m]) run[m] = 1'b1;
      end
      s = cyc % 4;
      for (int p = 0; p < 2; p++) begin
        ev[m][p] = sv[m][p][s];
        if (sv[m][p][s]) ed[m][p] = sd[m][p][s];
        sv[m][p][s] = 1'b0;
      end
    end
  endtask

  task automatic check_all();
    chk("busy0", busy0, !run[0]);
    chk("busy1", busy1, !run[1]);
    chk("douta0", douta0, ed[0][0]);
    chk("valida0", valida0, ev[0][0]);
    chk("doutb0", doutb0, ed[0][1]);
    chk("validb0", validb0, ev[0][1]);
    chk("douta1", douta1, ed[1][0]);
    chk("valida1", valida1, ev[1][0]);
    chk("doutb1", doutb1, ed[1][1]);
    chk("validb1", validb1, ev[1][1]);
    chk("col0", col0, ecol[0]);
    chk("col1", col1, ecol[1]);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
    @(negedge clk);
  endtask

  task automatic set_a(input logic e, input logic [3:0] we, input logic [3:0] a, input logic [31:0] d);
    ena = e; wea = we; addra = a; dina = d;
  endtask

  task automatic set_b(input logic e, input logic [3:0] we, input logic [3:0] a, input logic [31:0] d);
    enb = e; web = we; addrb = a; dinb = d;
  endtask

  task automatic idle();
    set_a(1'b0, 4'h0, 4'h0, 32'h0);
    set_b(1'b0, 4'h0, 4'h0, 32'h0);
  endtask

  task automatic rand_ports(input bit reads_only);
    ena   = reads_only ? 1'b1 : 1'($urandom_range(0, 1));
    enb   = reads_only ? 1'b1 : 1'($urandom_range(0, 1));
    wea   = (reads_only || $urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
    web   = (reads_only || $urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
    addra = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
    addrb = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(0, 3)) : 4'($urandom_range(0, 15));
    dina  = $urandom;
    dinb  = $urandom;
  endtask

  task automatic wait_sweep(input bit stream);
    fall0 = -1;
    fall1 = -1;
    for (int n = 1; n <= 40 && (fall0 < 0 || fall1 < 0); n++) begin
      if (stream) rand_ports(1'b1);
      cycle();
      if (fall0 < 0 && !busy0) fall0 = n;
      if (fall1 < 0 && !busy1) fall1 = n;
    end
    chk("sweep_len0", fall0, 16);
    chk("sweep_len1", fall1, 12);
  endtask

  initial begin
    idle();
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_all();
    cycle();
    cycle();
    rst_n = 1'b1;
    wait_sweep(1'b0);

    // Clear values after the sweep, latency and single-pulse valid.
    set_a(1'b1, 4'h0, 4'd15, 32'h0);
    set_b(1'b1, 4'h0, 4'd11, 32'h0);
    cycle();
    chk("clr_rd_b2", doutb1, 32'h5A5A0F0F);
    idle();
    chk("clr_vld_early", valida0, 1'b0);
    cycle();
    chk("clr_rd_a", douta0, 32'hA5A5A5A5);
    chk("clr_vld", valida0, 1'b1);
    cycle();
    chk("clr_vld_once", valida0, 1'b0);

    // Byte merge: WRITE_FIRST on port A, READ_FIRST on port B.
    set_a(1'b1, 4'hF, 4'd3, 32'h11223344);
    set_b(1'b1, 4'hF, 4'd4, 32'h11223344);
    cycle();
    set_a(1'b1, 4'h5, 4'd3, 32'hAABBCCDD);
    set_b(1'b1, 4'h5, 4'd4, 32'hAABBCCDD);
    cycle();
    idle();
    cycle();
    chk("merge_wf", douta0, 32'h11BB33DD);
    chk("merge_rf", doutb0, 32'h11223344);
    set_a(1'b1, 4'h0, 4'd3, 32'h0);
    set_b(1'b1, 4'h0, 4'd4, 32'h0);
    cycle();
    idle();
    cycle();
    chk("merge_rd_a", douta0, 32'h11BB33DD);
    chk("merge_rd_b", doutb0, 32'h11BB33DD);

    // Write/write collisions at address 7.
    set_a(1'b1, 4'hF, 4'd7, 32'h000000FF);
    set_b(1'b1, 4'hF, 4'd7, 32'hFFFFFF00);
    cycle();
    chk("ww_col", col0, 1'b1);
    idle();
    cycle();
    chk("ww_col_end", col0, 1'b0);
    set_a(1'b1, 4'h0, 4'd7, 32'h0);
    cycle();
    idle();
    cycle();
    chk("ww_store", douta0, 32'h000000FF);
    set_a(1'b1, 4'h1, 4'd7, 32'h000000FF);
    set_b(1'b1, 4'hE, 4'd7, 32'hFFFFFF00);
    cycle();
    chk("ww2_col", col0, 1'b1);
    set_a(1'b1, 4'h0, 4'd7, 32'h0);
    set_b(1'b0, 4'h0, 4'd0, 32'h0);
    cycle();
    idle();
    cycle();
    chk("ww2_store", douta0, 32'hFFFFFFFF);

    // Cross-port read during a write to the same address.
    set_a(1'b1, 4'hF, 4'd7, 32'h12345678);
    cycle();
    set_a(1'b1, 4'hF, 4'd7, 32'hCAFEF00D);
    set_b(1'b1, 4'h0, 4'd7, 32'h0);
    cycle();
    chk("xp_col", col0, 1'b1);
    idle();
    cycle();
    chk("xp_old", doutb0, 32'h12345678);
    set_b(1'b1, 4'h0, 4'd7, 32'h0);
    cycle();
    idle();
    cycle();
    chk("xp_new", doutb0, 32'hCAFEF00D);

    // NO_CHANGE on the second instance's port A.
    set_a(1'b1, 4'hF, 4'd2, 32'h55);
    cycle();
    set_a(1'b1, 4'h0, 4'd2, 32'h0);
    cycle();
    chk("nc_rd", douta1, 32'h55);
    chk("nc_vld", valida1, 1'b1);
    set_a(1'b1, 4'hF, 4'd2, 32'h66);
    cycle();
    chk("nc_hold", douta1, 32'h55);
    chk("nc_novld", valida1, 1'b0);
    set_a(1'b1, 4'h0, 4'd2, 32'h0);
    cycle();
    chk("nc_new", douta1, 32'h66);

    for (int n = 0; n < 400; n++) begin
      rand_ports(1'b0);
      cycle();
    end

    // Reset in the middle of a read stream.
    for (int n = 0; n < 5; n++) begin
      rand_ports(1'b1);
      cycle();
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all();
    chk("rst_douta", douta0, 32'h0);
    chk("rst_valida", valida0, 1'b0);
    chk("rst_doutb", doutb0, 32'h0);
    chk("rst_validb", validb0, 1'b0);
    chk("rst_busy", busy0, 1'b1);
    cycle();
    cycle();
    rst_n = 1'b1;
    wait_sweep(1'b1);

    for (int n = 0; n < 100; n++) begin
      rand_ports(1'b0);
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
